// File: rtl/bdi_pkg.sv
// Shared BDI definitions: encoding tags, per-encoding element geometry and
// the decompressor FSM states. Also used by the compressor.
package bdi_pkg;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned CHUNK_W = 64;
  localparam int unsigned ENC_W   = 3;

  typedef enum logic [2:0] {
    ENC_RAW  = 3'd0,
    ENC_B8D1 = 3'd1,
    ENC_B8D2 = 3'd2,
    ENC_B8D4 = 3'd3,
    ENC_B4D1 = 3'd4,
    ENC_B4D2 = 3'd5,
    ENC_B2D1 = 3'd6,
    ENC_ZERO = 3'd7
  } enc_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Indexed by enc_t; raw and all-zero carry no base/delta geometry.
  localparam logic [3:0] BASE_BYTES  [8] = '{4'd0, 4'd8, 4'd8, 4'd8, 4'd4, 4'd4, 4'd2, 4'd0};
  localparam logic [3:0] DELTA_BYTES [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd1, 4'd2, 4'd1, 4'd0};
  localparam logic [4:0] NUM_ELEMS   [8] = '{5'd0, 5'd4, 5'd4, 5'd4, 5'd8, 5'd8, 5'd16, 5'd0};
  localparam logic [8:0] USED_BITS   [8] = '{9'd256, 9'd96, 9'd128, 9'd192, 9'd96, 9'd160, 9'd144, 9'd0};

  function automatic logic [LINE_W-1:0] used_mask(input enc_t e);
    logic [LINE_W-1:0] m;
    for (int b = 0; b < int'(LINE_W); b++) begin
      m[b] = (b < int'(USED_BITS[e])) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  // Sign-extended delta of element 'elem', located just above the base.
  function automatic logic [CHUNK_W-1:0] delta_sx(input logic [LINE_W-1:0] p,
                                                  input enc_t e,
                                                  input logic [3:0] elem);
    logic [8:0]        lsb;
    logic [LINE_W-1:0] sh;
    lsb = {2'd0, BASE_BYTES[e], 3'd0} + ({5'd0, elem} * {2'd0, DELTA_BYTES[e], 3'd0});
    sh  = p >> lsb;
    if ({1'b0, elem} >= NUM_ELEMS[e]) begin
      return {CHUNK_W{1'b0}};
    end else begin
      case (DELTA_BYTES[e])
        4'd1:    return {{56{sh[7]}}, sh[7:0]};
        4'd2:    return {{48{sh[15]}}, sh[15:0]};
        4'd4:    return {{32{sh[31]}}, sh[31:0]};
        default: return {CHUNK_W{1'b0}};
      endcase
    end
  endfunction

endpackage

// File: rtl/bdi_chunk_expand.sv
// Combinational rebuild of one 64-bit chunk of a BDI line from the captured
// payload, encoding and chunk index.
module bdi_chunk_expand
  import bdi_pkg::*;
(
  input  logic [LINE_W-1:0]  data_i,
  input  logic [ENC_W-1:0]   enc_i,
  input  logic [1:0]         idx_i,
  output logic [CHUNK_W-1:0] chunk_o
);

  enc_t enc_s;
  assign enc_s = enc_t'(enc_i);

  // A chunk holds one 8-byte, two 4-byte or four 2-byte elements.
  always_comb begin : expand
    logic [CHUNK_W-1:0] dx;
    dx      = 64'd0;
    chunk_o = 64'd0;
    case (enc_s)
      ENC_RAW: chunk_o = data_i[{idx_i, 6'd0} +: CHUNK_W];
      ENC_B8D1, ENC_B8D2, ENC_B8D4: begin
        dx      = delta_sx(data_i, enc_s, {2'b00, idx_i});
        chunk_o = data_i[63:0] + dx;
      end
      ENC_B4D1, ENC_B4D2: begin
        for (int j = 0; j < 2; j++) begin
          dx = delta_sx(data_i, enc_s, {1'b0, idx_i, 1'(j)});
          chunk_o[j*32 +: 32] = data_i[31:0] + dx[31:0];
        end
      end
      ENC_B2D1: begin
        for (int j = 0; j < 4; j++) begin
          dx = delta_sx(data_i, enc_s, {idx_i, 2'(j)});
          chunk_o[j*16 +: 16] = data_i[15:0] + dx[15:0];
        end
      end
      default: chunk_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/bdi_decompressor.sv
// BDI line decompressor: accepts one compressed line, rebuilds it one chunk
// per cycle over four cycles, then holds it on a valid/ready output.
module bdi_decompressor
  import bdi_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ENC_W-1:0]  comp_enc,
  input  logic [LINE_W-1:0] comp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_data,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [LINE_W-1:0]   payload_q, payload_d;
  logic [ENC_W-1:0]    enc_q, enc_d;
  logic [LINE_W-1:0]   out_data_q, out_data_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [CHUNK_W-1:0]  chunk_s;

  bdi_chunk_expand u_expand (
    .data_i  (payload_q),
    .enc_i   (enc_q),
    .idx_i   (cnt_q),
    .chunk_o (chunk_s)
  );

  // Next-state and next-output logic for the IDLE/EXPAND/DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    payload_d   = payload_q;
    enc_d       = enc_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Unused payload bits are dropped at capture so they can never leak.
          payload_d  = comp_data & used_mask(enc_t'(comp_enc));
          enc_d      = comp_enc;
          out_data_d = {LINE_W{1'b0}};
          cnt_d      = 2'd0;
          state_d    = ST_EXPAND;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        out_data_d[{cnt_q, 6'd0} +: CHUNK_W] = chunk_s;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = ST_EXPAND;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 2'd0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      payload_q   <= {LINE_W{1'b0}};
      enc_q       <= {ENC_W{1'b0}};
      out_data_q  <= {LINE_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      payload_q   <= payload_d;
      enc_q       <= enc_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bdi_decompressor.sv
// Self-checking bench for bdi_decompressor: directed vectors, random lines
// against an element-level reference model, backpressure and mid-line reset.
module tb_bdi_decompressor;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   comp_enc;
  logic [255:0] comp_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  bdi_decompressor dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .comp_enc  (comp_enc),
    .comp_data (comp_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: every element = base + sign-extended delta, mod 2^(base bits).
  function automatic logic [255:0] ref_line(input int enc, input logic [255:0] d);
    logic [255:0] r;
    logic [63:0]  base, del, el;
    int bw, dw;
    r = '0;
    if (enc == 0) return d;
    if (enc == 7) return r;
    case (enc)
      1: begin bw = 64; dw = 8;  end
      2: begin bw = 64; dw = 16; end
      3: begin bw = 64; dw = 32; end
      4: begin bw = 32; dw = 8;  end
      5: begin bw = 32; dw = 16; end
      default: begin bw = 16; dw = 8; end
    endcase
    base = '0;
    for (int b = 0; b < bw; b++) base[b] = d[b];
    for (int i = 0; i < 256 / bw; i++) begin
      for (int b = 0; b < 64; b++)
        del[b] = (b < dw) ? d[bw + i*dw + b] : d[bw + i*dw + dw - 1];
      el = base + del;
      for (int b = 0; b < bw; b++) r[i*bw + b] = el[b];
    end
    return r;
  endfunction

  task automatic do_accept(input logic [2:0] enc, input logic [255:0] d);
    int k = 0;
    while (in_ready !== 1'b1 && k < 50) begin @(negedge clock); k++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    comp_enc = enc; comp_data = d; in_valid = 1'b1;
    @(negedge clock);
    in_valid  = 1'b0;
    comp_enc  = 3'($urandom);
    comp_data = rand256();
  endtask

  task automatic check_result(input logic [255:0] exp, input string name, input int hold);
    int lat = 0;
    bit flight_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) flight_ok = 1'b0;
      @(negedge clock); lat++;
    end
    n_cmp++;
    if (lat != 4) begin n_err++; $display("FAIL %s latency: got %0d required 4", name, lat); end
    n_cmp++;
    if (!flight_ok) begin n_err++; $display("FAIL %s in_flight: in_ready/busy wrong during expand, required 0/1", name); end
    n_cmp++;
    if (out_data !== exp) begin n_err++; $display("FAIL %s data: got %h required %h", name, out_data, exp); end
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
        n_err++; $display("FAIL %s hold%0d: valid=%b ready=%b data=%h required 1 0 %h", name, h, out_valid, in_ready, out_data, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL %s handshake: valid=%b ready=%b busy=%b required 0 1 0", name, out_valid, in_ready, busy);
    end
    n_cmp++;
    if (out_data !== exp) begin n_err++; $display("FAIL %s retain: got %h required %h", name, out_data, exp); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; comp_enc = 3'd0; comp_data = '0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 256'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset: ready=%b valid=%b busy=%b data=%h required 1 0 0 0", in_ready, out_valid, busy, out_data);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: ready=%b valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_directed();
    logic [255:0] d;
    d = rand256(); d[63:0] = 64'h1000; d[95:64] = 32'h7F44_2200;
    do_accept(3'd1, d);
    check_result({64'h107F, 64'h1044, 64'h1022, 64'h1000}, "b8d1", 0);

    d = rand256(); d[31:0] = 32'h100; d[95:32] = 64'h3020_107F_8001_00FF;
    do_accept(3'd4, d);
    check_result({32'h130, 32'h120, 32'h110, 32'h17F, 32'h80, 32'h101, 32'h100, 32'hFF}, "b4d1", 0);

    d = rand256(); d[143:0] = '0; d[15:0] = 16'hFFFF; d[23:16] = 8'h01;
    do_accept(3'd6, d);
    check_result({{15{16'hFFFF}}, 16'h0000}, "b2d1_wrap", 0);

    d[63:0] = 64'h1122_0000; d[95:64] = 32'h0; d[127:96] = 32'h1122;
    d[159:128] = 32'h5566; d[191:160] = 32'hFFFF_FFFF; d[255:192] = 64'hDEAD_BEEF_CAFE_F00D;
    do_accept(3'd3, d);
    check_result({64'h1121_FFFF, 64'h1122_5566, 64'h1122_1122, 64'h1122_0000}, "b8d4", 0);

    d = {4{64'hA5A5_A5A5_5A5A_5A5A}};
    do_accept(3'd0, d);
    check_result({4{64'hA5A5_A5A5_5A5A_5A5A}}, "raw", 0);

    d = rand256() | 256'd1;
    do_accept(3'd7, d);
    check_result(256'd0, "zero", 0);
  endtask

  task automatic test_random();
    logic [255:0] d;
    logic [2:0]   e;
    for (int i = 0; i < 24; i++) begin
      e = 3'($urandom_range(0, 7));
      d = rand256();
      do_accept(e, d);
      check_result(ref_line(int'(e), d), $sformatf("rand%0d_enc%0d", i, e), 0);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] d1, d2;
    d1 = rand256(); d2 = rand256();
    do_accept(3'd2, d1);
    comp_enc = 3'd5; comp_data = d2; in_valid = 1'b1;
    check_result(ref_line(2, d1), "bp_first", 3);
    @(negedge clock);
    in_valid = 1'b0; comp_data = rand256();
    check_result(ref_line(5, d2), "bp_second", 0);
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    d = rand256(); d[63:0] = 64'h0123_4567_89AB_CDEF;
    do_accept(3'd2, d);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 256'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: ready=%b valid=%b busy=%b data=%h required 1 0 0 0", in_ready, out_valid, busy, out_data);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    d = rand256();
    do_accept(3'd4, d);
    check_result(ref_line(4, d), "after_reset", 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
